cfg_prio_arbiter: RTL and testbench

//  Parametrised N-channel request arbiter with a runtime-selectable policy.

---
 rtl/cfg_prio_arbiter_pkg.sv | 8 +
 rtl/cfg_prio_arbiter_pick.sv | 50 +++++
 rtl/cfg_prio_arbiter.sv | 133 +++++++++++++
 tb/tb_cfg_prio_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cfg_prio_arbiter_pkg.sv
// Shared types for the configurable priority arbiter: policy select and FSM state encodings.
package arb_pkg;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_e;

endpackage

// File: rtl/cfg_prio_arbiter_pick.sv
// Combinational winner selection: lowest set index (fixed) or first set index at/after ptr (round-robin).
module arb_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  arb_mode_e        i_mode,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N_REQ-1:0] w_rot;
    int               w_sel;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = |i_req;
        w_rot = '0;
        w_sel = 0;
        case (i_mode)
            ARB_FIXED: begin
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (i_req[IDX_W'(i)]) o_idx = IDX_W'(i);
                end
            end
            ARB_RR: begin
                // rotate so ptr lands at bit 0, pick lowest, then rotate the index back
                for (int j = 0; j < N_REQ; j++) begin
                    w_rot[IDX_W'(j)] = i_req[IDX_W'((j + int'(i_ptr)) % N_REQ)];
                end
                for (int j = N_REQ - 1; j >= 0; j--) begin
                    if (w_rot[IDX_W'(j)]) w_sel = j;
                end
                o_idx = IDX_W'((w_sel + int'(i_ptr)) % N_REQ);
            end
            default: begin
                o_idx = '0;
                o_any = 1'b0;
            end
        endcase
        if (o_any) o_gnt[o_idx] = 1'b1;
        else       o_idx = '0;
    end

endmodule

// File: rtl/cfg_prio_arbiter.sv
// N-channel request arbiter with runtime fixed/round-robin policy, grant hold and hold-time preemption.
//   state   | meaning
//   ST_IDLE | no grant outstanding; any request triggers arbitration
//   ST_BUSY | one owner holds the grant until release or hold-limit preemption
module cfg_prio_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_mode,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid,
    output logic             o_timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_e        r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              r_timeout, w_to_nxt;

    logic [N_REQ-1:0]  w_mask;
    logic [N_REQ-1:0]  w_pick_gnt;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_owner_req;
    logic              w_at_limit;
    logic              w_take;

    // owner bit is already clear on release and r_gnt is zero in idle, so one mask serves all events
    assign w_mask      = i_req & ~r_gnt;
    assign w_owner_req = |(i_req & r_gnt);
    assign w_at_limit  = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);

    arb_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req  (w_mask),
        .i_ptr  (r_ptr),
        .i_mode (arb_mode_e'(i_mode)),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_to_nxt    = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_owner_req) begin
                    if (w_pick_any) begin
                        w_take = 1'b1;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_at_limit) begin
                    w_hold_nxt = '0;
                    if (w_pick_any) begin
                        w_take   = 1'b1;
                        w_to_nxt = 1'b1;
                    end
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
        if (w_take) begin
            w_gnt_nxt  = w_pick_gnt;
            w_idx_nxt  = w_pick_idx;
            w_hold_nxt = '0;
            if (i_mode == ARB_RR) w_ptr_nxt = IDX_W'((int'(w_pick_idx) + 1) % N_REQ);
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_idx;
    assign o_gnt_valid = |r_gnt;
    assign o_timeout   = r_timeout;

    a_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt));
    a_valid:  assert property (@(posedge i_clk) disable iff (i_rst) o_gnt_valid == (|o_gnt));
    a_idx:    assert property (@(posedge i_clk) disable iff (i_rst)
                               o_gnt_valid |-> (o_gnt == (N_REQ'(1) << o_gnt_idx)));
    a_idx0:   assert property (@(posedge i_clk) disable iff (i_rst) !o_gnt_valid |-> (o_gnt_idx == '0));

endmodule

// File: tb/tb_cfg_prio_arbiter.sv
// Directed, table-driven bench for cfg_prio_arbiter (N_REQ=4, MAX_HOLD=4).
module tb_cfg_prio_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       to;
        string      name;
    } vec_t;

    vec_t vecs[$];

    cfg_prio_arbiter #(.N_REQ(4), .MAX_HOLD(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_mode      (mode),
        .o_gnt       (gnt),
        .o_gnt_idx   (gnt_idx),
        .o_gnt_valid (gnt_valid),
        .o_timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei, input logic et);
        logic ev;
        ev = |eg;
        n_checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== {eg, ei, ev, et}) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
                     name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic m, input logic [3:0] g,
                       input logic [1:0] i, input logic t, input string n);
        vec_t v;
        v.req = r; v.mode = m; v.gnt = g; v.idx = i; v.to = t; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        foreach (vecs[k]) begin
            @(negedge clk);
            req  = vecs[k].req;
            mode = vecs[k].mode;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[k].name, k), vecs[k].gnt, vecs[k].idx, vecs[k].to);
        end
        vecs.delete();
    endtask

    initial begin
        logic [3:0] g;
        rst  = 1'b1;
        req  = 4'b0000;
        mode = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;

        // fixed priority, release hands over without an idle bubble
        add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, "t1_first");
        add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "t1_handoff");
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t1_idle");
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t1_idle2");

        // round-robin rotation by hold-limit preemption
        for (int k = 0; k < 4; k++) begin
            g = 4'b0001 << k;
            for (int c = 0; c < 4; c++)
                add(4'b1111, 1'b1, g, 2'(k), (c == 0 && k != 0), "t2_rot");
        end
        add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "t2_wrap");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t2_idle");

        // lone requester is never preempted (ptr 1 -> 3)
        for (int c = 0; c < 20; c++)
            add(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, "t3_hold");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t3_idle");

        // ch0 owns with ptr=1, same-edge handoff to ch3 leaves ptr=0
        add(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "t4_own0");
        add(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0, "t4_handoff");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t4_idle");
        add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, "t4_ptr0");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t4_idle2");
        run_table();

        // asynchronous reset while ch2 holds the grant
        @(negedge clk);
        req  = 4'b0100;
        mode = 1'b1;
        @(posedge clk);
        #1;
        check("t5_pre", 4'b0100, 2'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_after", 4'b0001, 2'd0, 1'b0);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("t5_idle", 4'b0000, 2'd0, 1'b0);

        // mode change while busy: owner kept, next event follows RR from ptr=1
        add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "t6_fixed");
        add(4'b0111, 1'b1, 4'b0100, 2'd2, 1'b0, "t6_keep");
        add(4'b0111, 1'b1, 4'b0100, 2'd2, 1'b0, "t6_keep2");
        add(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0, "t6_rr");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t6_idle");

        // fixed-mode preemption, ptr must stay at 2
        for (int c = 0; c < 4; c++)
            add(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "fx_hold0");
        add(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, "fx_pre1");
        for (int c = 0; c < 3; c++)
            add(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "fx_hold1");
        add(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, "fx_pre0");
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "fx_idle");
        add(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0, "fx_ptr2");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "fx_idle2");
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
